// File: rtl/interrupt_controller_pkg.sv
// irq_pkg: shared state, source and cause definitions for the interrupt controller.
package irq_pkg;
    typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_e;
    localparam int SRC_SSW  = 0;
    localparam int SRC_MSW  = 1;
    localparam int SRC_STIM = 2;
    localparam int SRC_MTIM = 3;
    localparam int SRC_SEXT = 4;
    localparam int SRC_MEXT = 5;
    localparam logic [5:0] CAUSE_SSW         = 6'h01;
    localparam logic [5:0] CAUSE_MSW         = 6'h03;
    localparam logic [5:0] CAUSE_STIM        = 6'h05;
    localparam logic [5:0] CAUSE_MTIM        = 6'h07;
    localparam logic [5:0] CAUSE_SEXT        = 6'h09;
    localparam logic [5:0] CAUSE_MEXT        = 6'h0B;
    localparam logic [5:0] CAUSE_CUSTOM_BASE = 6'h10;
    localparam logic [5:0] CAUSE_NONE        = 6'h1F;
    // Standard sources use odd codes 2*i+1; custom ones count up from the custom base.
    function automatic logic [5:0] cause_of(int idx);
        return idx <= SRC_MEXT ? 6'(2 * idx + 1) : 6'(int'(CAUSE_CUSTOM_BASE) + idx - (SRC_MEXT + 1));
    endfunction
endpackage

// File: rtl/interrupt_controller_if.sv
// irq_if: interrupt sources, CSR controls and trap handshake between controller and core.
interface irq_if #(parameter int NUM_SRC = 16, parameter int CODE_W = 6);
    logic [NUM_SRC-1:0] irq_in;
    logic [NUM_SRC-1:0] irq_en;
    logic               global_ie;
    logic [NUM_SRC-1:0] clr_pending;
    logic               trap_ack;
    logic               mret;
    logic               trap_req;
    logic [CODE_W-1:0]  trap_cause;
    logic [NUM_SRC-1:0] irq_pending;
    logic               busy;
    modport master (
        input  irq_in, irq_en, global_ie, clr_pending, trap_ack, mret,
        output trap_req, trap_cause, irq_pending, busy
    );
    modport slave (
        output irq_in, irq_en, global_ie, clr_pending, trap_ack, mret,
        input  trap_req, trap_cause, irq_pending, busy
    );
endinterface

// File: rtl/interrupt_controller_priority_encoder.sv
// irq_priority_encoder: lowest qualified source index wins; yields its cause code.
module irq_priority_encoder
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 16,
    parameter int CODE_W  = 6,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] qual_i,
    output logic [CODE_W-1:0]  cause_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);
    assign valid_o = |qual_i;
    always_comb begin
        cause_o = CODE_W'(CAUSE_NONE);
        idx_o   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (qual_i[i]) begin
                cause_o = CODE_W'(cause_of(i));
                idx_o   = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: synchronises sources into mip, arbitrates by fixed priority
// and runs a non-nesting request/ack/mret sequence toward the core's trap entry.
module interrupt_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = 16,
    parameter int CODE_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input logic   clk,
    input logic   rst_n,
    irq_if.master bus
);
    localparam int IDX_W = $clog2(NUM_SRC);
    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
    logic [NUM_SRC-1:0] hist_q, pend_q, pend_d, rise, qual, ack_clr;
    state_e             state_q, state_d;
    logic [CODE_W-1:0]  cause_q, cause_d, enc_cause;
    logic [IDX_W-1:0]   src_q, src_d, enc_idx;
    logic               enc_valid;

    irq_priority_encoder #(.NUM_SRC(NUM_SRC), .CODE_W(CODE_W)) u_enc (
        .qual_i (qual),
        .cause_o(enc_cause),
        .idx_o  (enc_idx),
        .valid_o(enc_valid)
    );

    assign rise    = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign qual    = pend_q & bus.irq_en;
    assign ack_clr = (state_q == REQ && bus.trap_ack) ? NUM_SRC'(1) << src_q : '0;
    // A fresh edge beats both the ack clear and the software clear.
    assign pend_d  = rise | (pend_q & ~ack_clr & ~bus.clr_pending);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        src_d   = src_q;
        case (state_q)
            IDLE: if (bus.global_ie && enc_valid) begin
                state_d = REQ;
                cause_d = enc_cause;
                src_d   = enc_idx;
            end
            REQ:     state_d = bus.trap_ack ? ACTIVE : (!bus.global_ie ? IDLE : REQ);
            ACTIVE:  state_d = bus.mret ? IDLE : ACTIVE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            hist_q  <= '0;
            pend_q  <= '0;
            state_q <= IDLE;
            cause_q <= CODE_W'(CAUSE_NONE);
            src_q   <= '0;
        end else begin
            sync_q[0] <= bus.irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            hist_q  <= sync_q[SYNC_STAGES-1];
            pend_q  <= pend_d;
            state_q <= state_d;
            cause_q <= cause_d;
            src_q   <= src_d;
        end
    end

    assign bus.trap_req    = state_q == REQ;
    assign bus.busy        = state_q != IDLE;
    assign bus.trap_cause  = state_q == IDLE ? enc_cause : cause_q;
    assign bus.irq_pending = pend_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed scenarios plus random traffic against a cycle-level reference model.
module tb_interrupt_controller;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    irq_if #(.NUM_SRC(16), .CODE_W(6)) bus ();
    interrupt_controller #(.NUM_SRC(16), .CODE_W(6), .SYNC_STAGES(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;
    // Reference model: raw-input delay line, pending set, and a mode 0=idle 1=requesting 2=in handler.
    logic [15:0] m_s0, m_s1, m_hist, m_pend;
    int          m_mode, m_src;
    logic [5:0]  m_cause;

    function automatic logic [5:0] code_of(logic [15:0] q);
        for (int i = 0; i < 16; i++) if (q[i]) return i < 6 ? 6'(2 * i + 1) : 6'(16 + i - 6);
        return 6'h1F;
    endfunction

    function automatic int idx_of(logic [15:0] q);
        for (int i = 0; i < 16; i++) if (q[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s0 = '0; m_s1 = '0; m_hist = '0; m_pend = '0;
        m_mode = 0; m_src = 0; m_cause = 6'h1F;
    endtask

    task automatic check_all();
        chk("trap_req", 32'(bus.trap_req), 32'(m_mode == 1));
        chk("trap_cause", 32'(bus.trap_cause), 32'(m_mode == 0 ? code_of(m_pend & bus.irq_en) : m_cause));
        chk("irq_pending", 32'(bus.irq_pending), 32'(m_pend));
        chk("busy", 32'(bus.busy), 32'(m_mode != 0));
    endtask

    task automatic tick();
        logic [15:0] qual, clr_ack, nxt;
        @(posedge clk);
        qual    = m_pend & bus.irq_en;
        clr_ack = (m_mode == 1 && bus.trap_ack) ? 16'(1) << m_src : '0;
        nxt     = (m_s1 & ~m_hist) | (m_pend & ~clr_ack & ~bus.clr_pending);
        if (m_mode == 0 && bus.global_ie && qual != 0) begin
            m_mode = 1; m_cause = code_of(qual); m_src = idx_of(qual);
        end else if (m_mode == 1) m_mode = bus.trap_ack ? 2 : (!bus.global_ie ? 0 : 1);
        else if (m_mode == 2 && bus.mret) m_mode = 0;
        m_hist = m_s1; m_s1 = m_s0; m_s0 = bus.irq_in; m_pend = nxt;
        #1 check_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic ack();
        bus.trap_ack = 1'b1; tick(); bus.trap_ack = 1'b0;
    endtask

    task automatic do_mret();
        bus.mret = 1'b1; tick(); bus.mret = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.irq_in = '0; bus.irq_en = 16'hFFFF; bus.global_ie = 1'b1;
        bus.clr_pending = '0; bus.trap_ack = 1'b0; bus.mret = 1'b0;
        model_reset();
        #12;
        check_all();
        chk("reset_cause", 32'(bus.trap_cause), 32'h1F);
        @(negedge clk) rst_n = 1'b1;
        // Single source: 3-cycle latency into pending, request one cycle later
        bus.irq_in[3] = 1'b1;
        ticks(2);
        chk("lat_not_yet", 32'(bus.irq_pending[3]), 32'h0);
        tick();
        chk("lat_pend3", 32'(bus.irq_pending[3]), 32'h1);
        tick();
        chk("mtim_req", 32'(bus.trap_req), 32'h1);
        chk("mtim_cause", 32'(bus.trap_cause), 32'h07);
        ack();
        chk("mtim_cleared", 32'(bus.irq_pending[3]), 32'h0);
        do_mret();
        chk("mtim_idle", 32'(bus.busy), 32'h0);
        // Priority between bits 1 and 5
        bus.irq_in = 16'h0022;
        ticks(4);
        chk("prio_msw", 32'(bus.trap_cause), 32'h03);
        ack(); do_mret(); ticks(2);
        chk("prio_mext", 32'(bus.trap_cause), 32'h0B);
        chk("prio_mext_req", 32'(bus.trap_req), 32'h1);
        ack(); do_mret();
        // Masked bit 1, custom bit 9, global disable
        bus.irq_in = '0; bus.irq_en[1] = 1'b0; bus.global_ie = 1'b0;
        ticks(3);
        bus.irq_in = 16'h0202;
        ticks(5);
        chk("mask_noreq", 32'(bus.trap_req), 32'h0);
        chk("mask_cause", 32'(bus.trap_cause), 32'h13);
        bus.global_ie = 1'b1;
        ticks(2); ack(); do_mret();
        bus.clr_pending = 16'h0002; tick(); bus.clr_pending = '0;
        bus.irq_en = 16'hFFFF;
        // Frozen cause while a higher-priority source arrives
        bus.irq_in = '0; ticks(3);
        bus.irq_in[4] = 1'b1; ticks(4);
        bus.irq_in[0] = 1'b1; ticks(4);
        chk("frozen_cause", 32'(bus.trap_cause), 32'h09);
        ack(); do_mret(); ticks(2);
        chk("served_ssw", 32'(bus.trap_cause), 32'h01);
        ack(); do_mret();
        // Withdraw, ack race, no nesting
        bus.irq_in = '0; ticks(3);
        bus.irq_in[2] = 1'b1; ticks(4);
        bus.global_ie = 1'b0; tick();
        chk("withdraw_req", 32'(bus.trap_req), 32'h0);
        chk("withdraw_pend", 32'(bus.irq_pending[2]), 32'h1);
        bus.global_ie = 1'b1; tick();
        bus.global_ie = 1'b0; ack(); bus.global_ie = 1'b1;
        chk("race_active", 32'(bus.busy), 32'h1);
        bus.irq_in[6] = 1'b1; ticks(5);
        chk("no_nest", 32'(bus.trap_req), 32'h0);
        do_mret(); ticks(1);
        chk("custom_req", 32'(bus.trap_req), 32'h1);
        chk("custom_cause", 32'(bus.trap_cause), 32'h10);
        ack(); do_mret();
        // Async reset while ACTIVE with pending 0x0030
        bus.irq_in = '0; ticks(3);
        bus.irq_in = 16'h0030; ticks(4); ack();
        bus.irq_in[4] = 1'b0; tick(); bus.irq_in[4] = 1'b1; ticks(3);
        chk("pre_reset_pend", 32'(bus.irq_pending), 32'h0030);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        chk("async_cause", 32'(bus.trap_cause), 32'h1F);
        bus.irq_in = '0;
        @(negedge clk) rst_n = 1'b1;
        ticks(6);
        chk("post_reset_quiet", 32'(bus.trap_req), 32'h0);
        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            bus.irq_in      = bus.irq_in ^ 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) bus.irq_en = 16'($urandom);
            bus.global_ie   = $urandom_range(0, 9) != 0;
            bus.clr_pending = $urandom_range(0, 7) == 0 ? 16'($urandom) : '0;
            bus.trap_ack    = $urandom_range(0, 2) == 0;
            bus.mret        = $urandom_range(0, 4) == 0;
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Sequences interrupt delivery into the RISC-V core's trap path.
- Synchronises and latches raw interrupt sources into a pending register (mip view).
- Qualifies pending sources with the per-source enable mask (mie) and the global enable (mstatus.MIE).
- Selects one source by fixed priority and runs a request/acknowledge handshake with the core's trap entry logic.
- Blocks further requests until the handler returns with mret. No nesting.

Parameters:
NUM_SRC, 16, number of interrupt sources (bit index = source id)
CODE_W, 6, width of the cause code
SYNC_STAGES, 2, flip-flop synchroniser depth on each irq_in bit

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
irq_in  in  NUM_SRC  raw asynchronous level sources (bit0 S-sw, 1 M-sw, 2 S-timer, 3 M-timer, 4 S-ext, 5 M-ext, 6..15 custom)
irq_en  in  NUM_SRC  per-source enable (mie)
global_ie  in  1  global interrupt enable (mstatus.MIE)
clr_pending  in  NUM_SRC  software clear of pending bits (CSR write to mip), one-cycle pulses
trap_ack  in  1  core has taken the trap at an instruction boundary
mret  in  1  one-cycle pulse, handler returned
trap_req  out  1  interrupt request to the core
trap_cause  out  CODE_W  cause code of the requested or active interrupt
irq_pending  out  NUM_SRC  pending register
busy  out  1  high in REQ and ACTIVE

Behaviour:
- Reset (rst_n low, asynchronous):
  - Synchroniser stages, edge-detect history and pending all clear to 0.
  - State = IDLE; trap_req = 0; busy = 0; trap_cause = 6'h1F.
- Synchronisation:
  - Each irq_in bit passes through SYNC_STAGES flops.
  - A rising edge of the synchronised bit sets the pending bit.
  - Latency from irq_in rising to irq_pending set is SYNC_STAGES+1 cycles (3 at default).
- Pending update, per bit, priority from highest:
  1. set by edge
  2. clear by trap_ack for the taken source
  3. clear by clr_pending
  4. hold
- Qualification: qual = irq_pending & irq_en. Candidate cause comes from the priority encoder.
- Priority and cause codes:
  - Lowest bit index wins.
  - Bits 0..5 map to codes 0x1, 0x3, 0x5, 0x7, 0x9, 0xB.
  - Custom bits 6..15 map to 0x10 + (index-6), i.e. 0x10..0x19.
  - No qualified source gives 0x1F.
- State machine:
  - IDLE
    - If global_ie and qual != 0: capture cause and source index into the frozen registers, go to REQ next cycle.
    - trap_cause shows the encoder output; it reads 0x1F when nothing is qualified.
  - REQ
    - trap_req = 1. trap_cause stays frozen even if a higher-priority source arrives or the chosen source is masked.
    - On trap_ack: clear the frozen source's pending bit and go to ACTIVE.
    - If global_ie drops without trap_ack: withdraw to IDLE with trap_req = 0 next cycle.
    - trap_ack and a global_ie drop in the same cycle: the ack wins.
  - ACTIVE
    - trap_req = 0; trap_cause holds the taken code. New pending bits still latch.
    - On mret: go to IDLE. Re-arbitration starts the following cycle, so the minimum gap between ack and the next trap_req is 2 cycles after mret.
- Simultaneous events:
  - Edge-set and clr_pending on the same bit: the set wins.
  - trap_ack outside REQ is ignored.
  - mret outside ACTIVE is ignored.

Decomposition:
- Shared package irq_pkg:
  - state enum {IDLE, REQ, ACTIVE}
  - source index constants (SRC_SSW=0 .. SRC_MEXT=5)
  - cause code constants, including CAUSE_NONE = 6'h1F and CAUSE_CUSTOM_BASE = 6'h10
- Sub-module irq_priority_encoder: purely combinational, qual vector in, cause code and source index out.

Test Plan:
- Reset then single source: rst_n low then high; irq_in[3] rises. irq_pending[3] is set 3 cycles later, trap_req rises the next cycle with trap_cause = 0x07. trap_ack clears irq_pending[3] and moves to ACTIVE; mret returns to IDLE.
- Priority: set pending bits 5 and 1 together with both enabled. trap_cause = 0x03; after ack and mret, the next request carries 0x0B.
- Masking and custom sources: irq_en[1] = 0 with bits 1 and 9 pending. trap_cause = 0x13; with global_ie = 0, trap_req never asserts and trap_cause reads 0x13 in IDLE.
- Frozen cause: in REQ with cause 0x09, bit 0 becomes pending. trap_cause remains 0x09 until ack; bit 0 is served (0x01) after mret.
- Withdraw, ack race and no nesting:
  - global_ie drops in REQ: trap_req falls next cycle, pending is kept.
  - Repeat with trap_ack in the same cycle: goes to ACTIVE.
  - A new source arriving in ACTIVE gives no trap_req until mret.
- Async reset mid-operation: assert rst_n low in ACTIVE with irq_pending = 0x0030. All outputs return to reset values immediately (trap_cause 0x1F, busy 0), with no request after release until fresh edges.
